// File: rtl/multiplier_controller_tainttrack.sv
// multiplier_controller_tainttrack
//   Control FSM for the taint-tracked sequential shift-add multiplier.
//   It sequences the load, clear, add and shift strobes over WIDTH
//   multiplier bits, then pulses done for one cycle.
//   All outputs are decoded from the registered state (Moore).
//   Every *_t output follows a sticky control-flow taint bit. That bit is
//   set when a start decision or a multiplier-bit decision depends on
//   tainted data.
//   Optional feature macro: TAINT_CLEAR_ON_IDLE_EN
//     When defined, the control taint is cleared on the DONE -> IDLE edge.
//     When undefined (the default), only rst clears it.
module multiplier_controller_tainttrack #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_ctrl_taint;
  logic             w_next_taint;
  logic             w_bit;
  logic             w_bit_t;

  assign w_bit   = multiplierReg[r_cnt];
  assign w_bit_t = multiplierReg_t[r_cnt];

  // State, bit counter and sticky control taint registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ctrl_taint <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_ctrl_taint <= w_next_taint;
    end
  end

  // Next-state, counter and taint-propagation logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_taint = r_ctrl_taint;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_INIT;
        // The stay-or-go decision is tainted even when start is low.
        if (start_t) w_next_taint = 1'b1;
      end
      S_INIT: begin
        w_next_cnt   = '0;
        w_next_state = S_CHECK;
      end
      S_CHECK: begin
        w_next_state = w_bit ? S_ADD : S_SHIFT;
        if (w_bit_t) w_next_taint = 1'b1;
      end
      S_ADD: begin
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_next_state = S_DONE;
        end else begin
          w_next_cnt   = r_cnt + CNT_W'(1);
          w_next_state = S_CHECK;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
`ifdef TAINT_CLEAR_ON_IDLE_EN
        w_next_taint = 1'b0;
`else
        w_next_taint = r_ctrl_taint;
`endif
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Moore strobe decode; every taint output mirrors the control taint
  always_comb begin
    mdld    = 1'b0;
    mrld    = 1'b0;
    rsclear = 1'b0;
    rsload  = 1'b0;
    rsshr   = 1'b0;
    done    = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_INIT: begin
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
      end
      S_ADD:   rsload = 1'b1;
      S_SHIFT: rsshr  = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
    mdld_t    = r_ctrl_taint;
    mrld_t    = r_ctrl_taint;
    rsclear_t = r_ctrl_taint;
    rsload_t  = r_ctrl_taint;
    rsshr_t   = r_ctrl_taint;
    busy_t    = r_ctrl_taint;
    done_t    = r_ctrl_taint;
  end

endmodule
